// File: rtl/csr_rmw_unit_pkg.sv
// CSR read-modify-write sequencer: shared types, CSR map constants
// and the bitwise update rule.
package csr_rmw_unit_pkg;

  localparam int CSR_ADDR_W = 12;
  localparam int XLEN       = 32;

  localparam logic [CSR_ADDR_W-1:0] CSR_REG_MSTATUS  = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] CSR_REG_MSCRATCH = 12'h340;
  localparam logic [CSR_ADDR_W-1:0] CSR_REG_MEPC     = 12'h341;
  localparam logic [CSR_ADDR_W-1:0] CSR_REG_CYCLE    = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_REG_INSTRET  = 12'hC02;

  typedef enum logic [1:0] {
    CSR_OP_RW   = 2'b00,
    CSR_OP_RS   = 2'b01,
    CSR_OP_RC   = 2'b10,
    CSR_OP_RSVD = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_rmw_state_t;

  // Top two address bits 2'b11 mark the read-only CSR space.
  function automatic logic csr_is_readonly(
    input logic [CSR_ADDR_W-1:0] addr
  );
    return addr[CSR_ADDR_W-1 -: 2] == 2'b11;
  endfunction

  function automatic logic [XLEN-1:0] csr_next_value(
    input csr_op_t         op,
    input logic [XLEN-1:0] old,
    input logic [XLEN-1:0] wdata
  );
    logic [XLEN-1:0] nv;
    nv = old;
    unique case (1'b1)
      op == CSR_OP_RW: nv = wdata;
      op == CSR_OP_RS: nv = old | wdata;
      op == CSR_OP_RC: nv = old & ~wdata;
      default:         nv = old;
    endcase
    return nv;
  endfunction

endpackage

// File: rtl/csr_rmw_unit.sv
// Single-transaction CSR sequencer: READ, optional one-cycle WRITE,
// then hold the old value as a response until it is consumed.
module csr_rmw_unit
  import csr_rmw_unit_pkg::*;
#(
  parameter int CSR_ADDR_W = 12,
  parameter int XLEN       = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [CSR_ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  input  logic                  req_src_nz_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_rdata_o,
  output logic                  resp_illegal_o,
  output logic [CSR_ADDR_W-1:0] csr_sel_o,
  output logic [XLEN-1:0]       csr_din_o,
  output logic                  csr_we_o,
  input  logic [XLEN-1:0]       csr_dout_i
);

  csr_rmw_state_t        state_q, state_d;
  csr_op_t               op_q, op_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic                  src_nz_q, src_nz_d;
  logic [XLEN-1:0]       old_q, old_d;
  logic [XLEN-1:0]       new_q, new_d;
  logic                  illegal_q, illegal_d;

  logic write_eff;
  logic illegal;

  assign write_eff = (op_q == CSR_OP_RW) || src_nz_q;
  assign illegal   = (op_q == CSR_OP_RSVD) ||
                     (write_eff && csr_is_readonly(addr_q));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      op_q      <= CSR_OP_RW;
      addr_q    <= '0;
      wdata_q   <= '0;
      src_nz_q  <= 1'b0;
      old_q     <= '0;
      new_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      src_nz_q  <= src_nz_d;
      old_q     <= old_d;
      new_q     <= new_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    src_nz_d       = src_nz_q;
    old_d          = old_q;
    new_d          = new_q;
    illegal_d      = illegal_q;
    req_ready_o    = 1'b0;
    resp_valid_o   = 1'b0;
    resp_rdata_o   = '0;
    resp_illegal_o = 1'b0;
    csr_sel_o      = '0;
    csr_din_o      = '0;
    csr_we_o       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d     = csr_op_t'(req_op_i);
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          src_nz_d = req_src_nz_i;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        csr_sel_o = addr_q;
        old_d     = csr_dout_i;
        new_d     = csr_next_value(op_q, csr_dout_i, wdata_q);
        illegal_d = illegal;
        state_d   = (write_eff && !illegal) ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        csr_sel_o = addr_q;
        csr_din_o = new_q;
        csr_we_o  = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        csr_sel_o      = addr_q;
        resp_valid_o   = 1'b1;
        resp_rdata_o   = illegal_q ? '0 : old_q;
        resp_illegal_o = illegal_q;
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Bench for csr_rmw_unit with a behavioural CSR file:
// 0x340 read/write scratch, 0xC00 free-running read-only counter.
module tb_csr_rmw_unit;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        req_src_nz_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_illegal_o;
  logic [11:0] csr_sel_o;
  logic [31:0] csr_din_o;
  logic        csr_we_o;
  logic [31:0] csr_dout_i;

  csr_rmw_unit #(.CSR_ADDR_W(12), .XLEN(32)) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_addr_i    (req_addr_i),
    .req_wdata_i   (req_wdata_i),
    .req_src_nz_i  (req_src_nz_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_rdata_o  (resp_rdata_o),
    .resp_illegal_o(resp_illegal_o),
    .csr_sel_o     (csr_sel_o),
    .csr_din_o     (csr_din_o),
    .csr_we_o      (csr_we_o),
    .csr_dout_i    (csr_dout_i)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] mscratch   = 32'h0;
  logic [31:0] cycle_cnt  = 32'h100;
  int          we_cnt     = 0;
  logic [31:0] last_din   = 32'h0;
  logic        preset_en  = 1'b0;
  logic [31:0] preset_val = 32'h0;

  always @(posedge clk_i) begin
    cycle_cnt <= cycle_cnt + 32'd1;
    if (preset_en)
      mscratch <= preset_val;
    else if (csr_we_o && csr_sel_o == 12'h340)
      mscratch <= csr_din_o;
    if (csr_we_o) begin
      we_cnt   <= we_cnt + 1;
      last_din <= csr_din_o;
    end
  end

  always_comb begin
    csr_dout_i = 32'h0;
    if (csr_sel_o == 12'h340) csr_dout_i = mscratch;
    else if (csr_sel_o == 12'hC00) csr_dout_i = cycle_cnt;
  end

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        nz;
    logic [31:0] pre;
    logic        use_cnt;
    logic [31:0] rdata;
    logic        ill;
    int          we;
    logic [31:0] model;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   tests  = 0;
  int   failed = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input bit do_preset,
                         input string nm);
    int   we0;
    int   lat;
    exp_t e;
    if (do_preset) begin
      @(negedge clk_i);
      preset_en  = 1'b1;
      preset_val = v.pre;
    end
    @(negedge clk_i);
    preset_en    = 1'b0;
    we0          = we_cnt;
    req_op_i     = v.op;
    req_addr_i   = v.addr;
    req_wdata_i  = v.wdata;
    req_src_nz_i = v.nz;
    req_valid_i  = 1'b1;
    e.rdata = v.use_cnt ? cycle_cnt + 32'd1 : v.rdata;
    e.ill   = v.ill;
    e.lat   = v.lat;
    sb.push_back(e);
    chk({nm, " req_ready"}, 32'(req_ready_o), 32'd1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_i);
      #1;
      if (k == 1) req_valid_i = 1'b0;
      if (resp_valid_o) begin
        lat = k;
        break;
      end
    end
    e = sb.pop_front();
    chk({nm, " latency"}, 32'(lat), 32'(e.lat));
    chk({nm, " rdata"}, resp_rdata_o, e.rdata);
    chk({nm, " illegal"}, 32'(resp_illegal_o), 32'(e.ill));
    chk({nm, " we pulses"}, 32'(we_cnt - we0), 32'(v.we));
    if (v.we != 0) chk({nm, " din"}, last_din, v.model);
    if (resp_ready_i) begin
      @(posedge clk_i);
      #1;
      chk({nm, " idle ready"}, 32'(req_ready_o), 32'd1);
      chk({nm, " idle valid"}, 32'(resp_valid_o), 32'd0);
    end
    chk({nm, " model"}, mscratch, v.model);
  endtask

  initial begin
    vec_t bp;
    reset_ni     = 1'b0;
    req_valid_i  = 1'b0;
    req_op_i     = 2'b00;
    req_addr_i   = 12'h0;
    req_wdata_i  = 32'h0;
    req_src_nz_i = 1'b0;
    resp_ready_i = 1'b1;

    //           op     addr    wdata         nz    pre           cnt   rdata         ill   we model         lat
    vecs[0] = '{2'b00, 12'h340, 32'hDEADBEEF, 1'b1, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 1, 32'hDEADBEEF, 3};
    vecs[1] = '{2'b01, 12'h340, 32'h0000000F, 1'b1, 32'h000000F0, 1'b0, 32'h000000F0, 1'b0, 1, 32'h000000FF, 3};
    vecs[2] = '{2'b10, 12'h340, 32'h0000003C, 1'b1, 32'h000000FF, 1'b0, 32'h000000FF, 1'b0, 1, 32'h000000C3, 3};
    vecs[3] = '{2'b01, 12'hC00, 32'h00000000, 1'b0, 32'h0000A5A5, 1'b1, 32'h0,        1'b0, 0, 32'h0000A5A5, 2};
    vecs[4] = '{2'b00, 12'hC00, 32'h00000005, 1'b1, 32'h00001111, 1'b0, 32'h0,        1'b1, 0, 32'h00001111, 2};
    vecs[5] = '{2'b11, 12'h340, 32'hFFFFFFFF, 1'b1, 32'h00000055, 1'b0, 32'h0,        1'b1, 0, 32'h00000055, 2};
    vecs[6] = '{2'b01, 12'h340, 32'h00000000, 1'b0, 32'h00000077, 1'b0, 32'h00000077, 1'b0, 0, 32'h00000077, 2};
    vecs[7] = '{2'b10, 12'hC00, 32'h00000001, 1'b1, 32'h00000033, 1'b0, 32'h0,        1'b1, 0, 32'h00000033, 2};
    vecs[8] = '{2'b00, 12'h340, 32'h00000000, 1'b0, 32'h00000099, 1'b0, 32'h00000099, 1'b0, 1, 32'h00000000, 3};

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst req_ready", 32'(req_ready_o), 32'd1);
    chk("rst resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst rdata", resp_rdata_o, 32'h0);
    chk("rst illegal", 32'(resp_illegal_o), 32'd0);
    chk("rst we", 32'(csr_we_o), 32'd0);
    chk("rst sel", 32'(csr_sel_o), 32'd0);
    chk("rst din", csr_din_o, 32'h0);
    @(negedge clk_i);
    reset_ni = 1'b1;

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Stalled response, then a back-to-back request.
    resp_ready_i = 1'b0;
    run_txn(vecs[1], 1'b1, "bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      chk("bp valid", 32'(resp_valid_o), 32'd1);
      chk("bp rdata", resp_rdata_o, 32'h000000F0);
      chk("bp req_ready", 32'(req_ready_o), 32'd0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("bp release ready", 32'(req_ready_o), 32'd1);
    chk("bp release valid", 32'(resp_valid_o), 32'd0);
    bp = '{2'b10, 12'h340, 32'h000000F0, 1'b1, 32'h0, 1'b0,
           32'h000000FF, 1'b0, 1, 32'h0000000F, 3};
    run_txn(bp, 1'b0, "b2b");

    // Reset asserted mid-WRITE must kill the write strobe at once.
    @(negedge clk_i);
    preset_en  = 1'b1;
    preset_val = 32'h00001111;
    @(negedge clk_i);
    preset_en    = 1'b0;
    req_op_i     = 2'b00;
    req_addr_i   = 12'h340;
    req_wdata_i  = 32'h00002222;
    req_src_nz_i = 1'b1;
    req_valid_i  = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("mid-write we", 32'(csr_we_o), 32'd1);
    reset_ni = 1'b0;
    #1;
    chk("async rst we", 32'(csr_we_o), 32'd0);
    chk("async rst ready", 32'(req_ready_o), 32'd1);
    chk("async rst valid", 32'(resp_valid_o), 32'd0);
    chk("async rst sel", 32'(csr_sel_o), 32'd0);
    chk("async rst din", csr_din_o, 32'h0);
    @(posedge clk_i);
    #1;
    chk("async rst model", mscratch, 32'h00001111);
    @(negedge clk_i);
    reset_ni = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
